// File: rtl/ram_1w_1rs_sc.sv
// Simple dual-port RAM: one masked write port, one synchronous read port, self-clearing after reset.
// Optional per-lane even parity when RAM_PARITY_EN is defined.
module ram_1w_1rs_sc #(
    parameter int WORD_COUNT = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int RUW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  wr_en_i,
    input  logic [MASK_WIDTH-1:0] wr_mask_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  init_done_o,
    output logic [MASK_WIDTH-1:0] parity_err_o
);
    localparam int LW = DATA_WIDTH / MASK_WIDTH;
    localparam logic [ADDR_WIDTH:0]   WC   = (ADDR_WIDTH+1)'(WORD_COUNT);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WORD_COUNT - 1);

    if (DATA_WIDTH % MASK_WIDTH != 0) begin : g_bad_mask
        $error("DATA_WIDTH must be divisible by MASK_WIDTH");
    end
    if (WORD_COUNT < 1 || WORD_COUNT > 2**ADDR_WIDTH) begin : g_bad_depth
        $error("WORD_COUNT must be in 1..2**ADDR_WIDTH");
    end

    typedef enum logic {CLEAR, READY} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0] mem_q [WORD_COUNT];

    logic                  wr_ok, rd_fire, wr_rng, rd_rng;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [MASK_WIDTH-1:0] rd_perr;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic [MASK_WIDTH-1:0] perr_q;

    assign wr_rng  = ({1'b0, wr_addr_i} < WC);
    assign rd_rng  = ({1'b0, rd_addr_i} < WC);
    assign wr_ok   = (state_q == READY) && wr_en_i && wr_rng;
    assign rd_fire = (state_q == READY) && rd_en_i;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST) state_d = READY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Storage has no reset of its own; the sweep provides deterministic contents.
    always_ff @(posedge clk_i) begin
        if (state_q == CLEAR) begin
            mem_q[clr_addr_q] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < MASK_WIDTH; i++)
                if (wr_mask_i[i]) mem_q[wr_addr_i][i*LW +: LW] <= wr_data_i[i*LW +: LW];
        end
    end

`ifdef RAM_PARITY_EN
    logic [MASK_WIDTH-1:0] par_q [WORD_COUNT];
    logic [MASK_WIDTH-1:0] rd_par;

    always_ff @(posedge clk_i) begin
        if (state_q == CLEAR) begin
            par_q[clr_addr_q] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < MASK_WIDTH; i++)
                if (wr_mask_i[i]) par_q[wr_addr_i][i] <= ^wr_data_i[i*LW +: LW];
        end
    end
`endif

    always_comb begin
        rd_word = '0;
        rd_perr = '0;
`ifdef RAM_PARITY_EN
        rd_par  = '0;
`endif
        if (rd_rng) begin
            rd_word = mem_q[rd_addr_i];
`ifdef RAM_PARITY_EN
            rd_par  = par_q[rd_addr_i];
`endif
            // Write-first: bypass freshly written lanes (and their parity) to the read.
            if (RUW_MODE == 1 && wr_ok && wr_addr_i == rd_addr_i) begin
                for (int i = 0; i < MASK_WIDTH; i++) begin
                    if (wr_mask_i[i]) begin
                        rd_word[i*LW +: LW] = wr_data_i[i*LW +: LW];
`ifdef RAM_PARITY_EN
                        rd_par[i] = ^wr_data_i[i*LW +: LW];
`endif
                    end
                end
            end
        end
`ifdef RAM_PARITY_EN
        for (int i = 0; i < MASK_WIDTH; i++)
            rd_perr[i] = (^rd_word[i*LW +: LW]) ^ rd_par[i];
`endif
    end

    if (OUT_REG == 0) begin : g_direct
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
                perr_q     <= '0;
            end else begin
                rd_valid_q <= rd_fire;
                perr_q     <= rd_fire ? rd_perr : '0;
                if (rd_fire) rd_data_q <= rd_word;
            end
        end
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0] s1_data_q;
        logic                  s1_vld_q;
        logic [MASK_WIDTH-1:0] s1_perr_q;

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                s1_data_q  <= '0;
                s1_vld_q   <= 1'b0;
                s1_perr_q  <= '0;
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
                perr_q     <= '0;
            end else begin
                s1_vld_q   <= rd_fire;
                s1_perr_q  <= rd_fire ? rd_perr : '0;
                if (rd_fire) s1_data_q <= rd_word;
                rd_valid_q <= s1_vld_q;
                perr_q     <= s1_vld_q ? s1_perr_q : '0;
                if (s1_vld_q) rd_data_q <= s1_data_q;
            end
        end
    end

    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign parity_err_o = perr_q;
    assign init_done_o  = (state_q == READY);

endmodule
